// File: rtl/d_ff_pr_pkg.sv
// d_ff_pr_pkg: control polarity and the shared set/clear gating rule
// used by both latch stages of the flip-flop.
package d_ff_pr_pkg;

   localparam logic ACTIVE = 1'b0;

   // Returns {q, qb}; both set and clear active drives both high.
   function automatic logic [1:0] gate(
      input logic d,
      input logic s_n,
      input logic r_n
   );
      logic s;
      logic r;
      s = (s_n == ACTIVE);
      r = (r_n == ACTIVE);
      return {s | (~r & d), r | (~s & ~d)};
   endfunction

endpackage

// File: rtl/d_ff_pr_latch.sv
// d_latch_pr: level-sensitive D latch with gated set/clear,
// holding q and qb as independent bits.
import d_ff_pr_pkg::*;

module d_latch_pr (
   output logic q,
   output logic qb,
   input  logic d,
   input  logic en,
   input  logic s_n,
   input  logic r_n
);

   always_latch begin
      if (en) begin
         {q, qb} <= gate(d, s_n, r_n);
      end
   end

endmodule

// File: rtl/d_ff_pr.sv
// d_ff_pr: rising-edge D flip-flop with synchronous active-low
// preset/reset, built from a master-slave pair of latches.
import d_ff_pr_pkg::*;

module d_ff_pr (
   output logic Q,
   output logic Qbar,
   input  logic D,
   input  logic C,
   input  logic nP,
   input  logic nR
);

   logic c_n;
   logic m_q;
   logic m_qb;
   logic s_set_n;
   logic s_clr_n;

   assign c_n = ~C;

   // Controls are folded into the master so they only act at the edge.
   d_latch_pr master (
      .q   (m_q),
      .qb  (m_qb),
      .d   (D),
      .en  (c_n),
      .s_n (nP),
      .r_n (nR)
   );

   // Slave re-expresses the master pair as set/clear so 1/1 survives.
   assign s_set_n = ~m_q;
   assign s_clr_n = ~m_qb;

   d_latch_pr slave (
      .q   (Q),
      .qb  (Qbar),
      .d   (m_q),
      .en  (C),
      .s_n (s_set_n),
      .r_n (s_clr_n)
   );

endmodule

// File: tb/tb_d_ff_pr.sv
// tb_d_ff_pr: vector table, hand sequences for hold/synchronicity,
// and random stimulus against a rule-based reference.
module tb_d_ff_pr;

   logic C;
   logic D;
   logic nP;
   logic nR;
   logic Q;
   logic Qbar;

   int total;
   int passed;

   typedef struct {
      string name;
      logic  d;
      logic  p;
      logic  r;
      logic  eq;
      logic  eqb;
   } vec_t;

   vec_t vecs[$];

   d_ff_pr dut (
      .Q    (Q),
      .Qbar (Qbar),
      .D    (D),
      .C    (C),
      .nP   (nP),
      .nR   (nR)
   );

   initial C = 1'b0;
   always #5 C = ~C;

   function automatic logic [1:0] model(
      input logic d,
      input logic p,
      input logic r
   );
      if (!p && !r) return 2'b11;
      if (!p) return 2'b10;
      if (!r) return 2'b01;
      return {d, ~d};
   endfunction

   task automatic chk(
      input string name,
      input logic eq,
      input logic eqb
   );
      total++;
      if (Q === eq && Qbar === eqb) begin
         passed++;
      end else begin
         $display("FAIL %s: Q/Qbar=%b/%b expected %b/%b",
                  name, Q, Qbar, eq, eqb);
      end
   endtask

   task automatic set_in(
      input logic d,
      input logic p,
      input logic r
   );
      D  = d;
      nP = p;
      nR = r;
   endtask

   task automatic edge_chk(
      input string name,
      input logic d,
      input logic p,
      input logic r
   );
      logic [1:0] e;
      @(negedge C);
      #1 set_in(d, p, r);
      e = model(d, p, r);
      @(posedge C);
      #1 chk(name, e[1], e[0]);
   endtask

   initial begin
      logic [1:0] e;
      logic       d;
      logic       p;
      logic       r;
      total  = 0;
      passed = 0;
      set_in(1'b0, 1'b1, 1'b0);

      vecs.push_back('{"reset_d0",   0, 1, 0, 0, 1});
      vecs.push_back('{"reset_d1",   1, 1, 0, 0, 1});
      vecs.push_back('{"preset_d0",  0, 0, 1, 1, 0});
      vecs.push_back('{"preset_d1",  1, 0, 1, 1, 0});
      vecs.push_back('{"capture_0",  0, 1, 1, 0, 1});
      vecs.push_back('{"capture_1",  1, 1, 1, 1, 0});
      vecs.push_back('{"both_low",   0, 0, 0, 1, 1});
      vecs.push_back('{"both_rel",   0, 1, 1, 0, 1});
      vecs.push_back('{"both_low_1", 1, 0, 0, 1, 1});
      vecs.push_back('{"both_hold",  0, 0, 0, 1, 1});
      vecs.push_back('{"capture_1b", 1, 1, 1, 1, 0});

      @(posedge C);
      #1 chk("reset_state", 1'b0, 1'b1);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge C);
         #1 set_in(vecs[i].d, vecs[i].p, vecs[i].r);
         @(posedge C);
         #1 chk(vecs[i].name, vecs[i].eq, vecs[i].eqb);
      end

      // nR dropped while C high: no effect until the next rising edge
      edge_chk("sync_setup", 1'b1, 1'b1, 1'b1);
      #2 nR = 1'b0;
      #1 chk("sync_rst_hi", 1'b1, 1'b0);
      @(negedge C);
      #2 chk("sync_rst_lo", 1'b1, 1'b0);
      @(posedge C);
      #1 chk("sync_rst_edge", 1'b0, 1'b1);

      // nP dropped while C high
      #1 nR = 1'b1;
      nP = 1'b0;
      #1 chk("sync_pre_hi", 1'b0, 1'b1);
      @(posedge C);
      #1 chk("sync_pre_edge", 1'b1, 1'b0);

      // D toggled between edges with Q=1
      edge_chk("hold_setup", 1'b1, 1'b1, 1'b1);
      #1 D = 1'b0;
      #1 chk("hold_d_hi", 1'b1, 1'b0);
      @(negedge C);
      #1 D = 1'b1;
      #1 D = 1'b0;
      #1 chk("hold_d_lo", 1'b1, 1'b0);
      D = 1'b1;
      @(posedge C);
      #1 chk("hold_d_edge", 1'b1, 1'b0);

      // falling edge alone never updates
      #1 D = 1'b0;
      @(negedge C);
      #1 chk("fall_only", 1'b1, 1'b0);
      @(posedge C);
      #1 chk("fall_then_rise", 1'b0, 1'b1);

      // random stimulus with mid-high-phase disturbances
      for (int i = 0; i < 300; i++) begin
         d = 1'($urandom);
         p = ($urandom_range(3) != 0);
         r = ($urandom_range(3) != 0);
         @(negedge C);
         #1 set_in(d, p, r);
         e = model(d, p, r);
         @(posedge C);
         #1 chk("rand_edge", e[1], e[0]);
         #1 set_in(1'($urandom), 1'($urandom), 1'($urandom));
         #1 chk("rand_hold", e[1], e[0]);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
